fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_W, 8, FIFO data width
  CNT_W, 4, width of FIFO occupancy count
  BURST_LEN, 4, words per burst in burst mode (1..2^CNT_W-1)
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  sole clock, all logic on rising edge
  rst  in  1  synchronous reset, active-high
  enable  in  1  permit new FIFO reads
  burst_mode  in  1  1 = burst reads gated by threshold; 0 = continuous
  flush  in  1  level; overrides threshold wait in burst mode
  buf_empty  in  1  FIFO empty flag
  fifo_counter  in  CNT_W  FIFO occupancy
  data_out  in  DATA_W  FIFO read data, valid the cycle after rd_enb
  rd_enb  out  1  FIFO read strobe
  m_data  out  DATA_W  downstream data
  m_valid  out  1  downstream valid
  m_ready  in  1  downstream ready
  burst_done  out  1  one-cycle pulse when last read of a burst issues
  rd_count  out  16  total words delivered downstream, wraps
REQ-003 One clock (clk); reset rst is synchronous and active-high.

Function
REQ-004 FIFO read latency: data_out sampled exactly one cycle after the cycle rd_enb=1; one in-flight flag tracks it.
REQ-005 Output buffer: 2-entry in-order register buffer; m_data/m_valid driven from head entry registers.
REQ-006 Transfer: word leaves when m_valid && m_ready; m_data and m_valid held stable while m_valid && !m_ready.
REQ-007 Read credit: rd_enb permitted only if occ + inflight - pop < 2 (pop = m_valid && m_ready this cycle); buffer never overflows.
REQ-008 rd_enb never asserted while buf_empty=1.
REQ-009 Throughput: with m_ready=1 and FIFO non-empty, one word per cycle sustained; first m_valid two cycles after first rd_enb.
REQ-010 FSM states IDLE, FILL, STREAM.
REQ-011 IDLE: no reads; -> STREAM if enable && !burst_mode; -> FILL if enable && burst_mode.
REQ-012 FILL: no reads; -> STREAM when fifo_counter >= BURST_LEN or flush=1; -> IDLE if enable=0.
REQ-013 STREAM, burst_mode=0: read per REQ-007/008 continuously; -> IDLE if enable=0.
REQ-014 STREAM, burst_mode=1: burst counter counts issued reads; on BURST_LEN-th read pulse burst_done, clear counter, -> FILL.
REQ-015 Flush in STREAM burst: if buf_empty before BURST_LEN reads, burst terminates without burst_done, counter cleared, -> FILL.
REQ-016 enable falling: no rd_enb from that cycle; -> IDLE; burst counter cleared; in-flight and buffered words still delivered.
REQ-017 burst_mode change takes effect only in IDLE or FILL.
REQ-018 rd_count increments by 1 per downstream transfer, wraps 0xFFFF -> 0x0000.
REQ-019 Simultaneous capture and pop on same cycle: occupancy unchanged, order preserved.

Reset
REQ-020 On rst=1 at rising edge: state IDLE; rd_enb=0, m_valid=0, m_data=0, burst_done=0, rd_count=0; buffer, in-flight flag, burst counter cleared.
REQ-021 Reset mid-operation: data_out arriving the cycle after reset is discarded; no downstream transfer until new reads issue.

Verification
REQ-022 Continuous: burst_mode=0, FIFO holds 0x11..0x15, m_ready=1 -> m_data 0x11..0x15 on 5 consecutive cycles, rd_count=5, rd_enb never with buf_empty=1.
REQ-023 Backpressure: m_ready=0 for 6 cycles mid-stream -> at most 2 words read ahead, m_data stable, no loss/duplication after release.
REQ-024 Burst: BURST_LEN=4, fifo_counter rises 0->3 -> no reads; at 4 -> exactly 4 rd_enb, one burst_done on 4th, state FILL.
REQ-025 Flush: burst_mode=1, fifo_counter=2, flush=1 -> 2 words delivered, no burst_done, return to FILL.
REQ-026 Reset mid-burst: rst=1 cycle after rd_enb -> following data_out ignored, m_valid=0, rd_count=0.
REQ-027 Wrap: preload 0xFFFE transfers, deliver 3 more -> rd_count=0x0001.

Source files
------------

// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port and downstream valid/ready stream bundled for fifo_reader.
interface fifo_reader_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              rd_enb;
  logic              buf_empty;
  logic [CNT_W-1:0]  fifo_counter;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output rd_enb, m_data, m_valid,
    input  buf_empty, fifo_counter, data_out, m_ready
  );

  modport slave (
    input  rd_enb, m_data, m_valid,
    output buf_empty, fifo_counter, data_out, m_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - drains a one-cycle-latency FIFO into a 2-entry valid/ready buffer,
// either continuously or in threshold-gated bursts.
module fifo_reader #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          burst_mode,
  input  logic          flush,
  fifo_reader_if.master bus,
  output logic          burst_done,
  output logic [15:0]   rd_count
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t            state;
  logic              burst_r;
  logic [CNT_W-1:0]  burst_cnt;
  logic              inflight;
  logic              head_valid;
  logic              tail_valid;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] tail_data;
  logic              pop;
  logic              rd;
  logic              last_read;
  logic              credit_ok;
  logic [2:0]        load;

  assign pop = head_valid && bus.m_ready;

  // Words already committed (buffered or in flight) minus the one leaving now must stay below 2.
  always_comb begin
    load      = {2'b00, head_valid} + {2'b00, tail_valid} + {2'b00, inflight};
    credit_ok = load < (3'd2 + {2'b00, pop});
  end

  assign rd        = !rst && (state == STREAM) && enable && !bus.buf_empty && credit_ok;
  assign last_read = rd && burst_r && (burst_cnt == CNT_W'(BURST_LEN - 1));

  assign bus.rd_enb  = rd;
  assign bus.m_data  = head_data;
  assign bus.m_valid = head_valid;
  assign burst_done  = last_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_r   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_r   <= burst_mode;
          burst_cnt <= '0;
          if (enable) state <= burst_mode ? FILL : STREAM;
        end
        FILL: begin
          burst_r   <= burst_mode;
          burst_cnt <= '0;
          if (!enable)
            state <= IDLE;
          else if (!burst_mode || (bus.fifo_counter >= CNT_W'(BURST_LEN)) ||
                   (flush && !bus.buf_empty))
            state <= STREAM;
        end
        STREAM: begin
          if (!enable) begin
            state     <= IDLE;
            burst_cnt <= '0;
          end else if (burst_r) begin
            if (last_read || (flush && bus.buf_empty)) begin
              state     <= FILL;
              burst_cnt <= '0;
            end else if (rd) begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The in-flight flag marks that data_out carries a word this cycle; clearing it on reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
      rd_count   <= '0;
    end else begin
      inflight <= rd;
      if (pop) rd_count <= rd_count + 16'd1;
      if (!head_valid) begin
        if (inflight) begin
          head_data  <= bus.data_out;
          head_valid <= 1'b1;
        end
      end else if (pop) begin
        if (tail_valid) begin
          head_data  <= tail_data;
          tail_valid <= inflight;
          if (inflight) tail_data <= bus.data_out;
        end else begin
          head_valid <= inflight;
          if (inflight) head_data <= bus.data_out;
        end
      end else if (inflight) begin
        tail_data  <= bus.data_out;
        tail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed bench for fifo_reader with a queue-based FIFO model.
module tb_fifo_reader;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        burst_mode;
  logic        flush;
  logic        burst_done;
  logic [15:0] rd_count;

  fifo_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .burst_mode (burst_mode),
    .flush      (flush),
    .bus        (bus),
    .burst_done (burst_done),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int cyc, n_rd, n_del, n_bd, bd_rd;
  int empty_viol, en_viol, stable_viol, order_err, max_out;
  int first_rd, first_val;
  int base, bd_base, dl;
  logic       prev_stall;
  logic [7:0] prev_data;
  int passed, total;

  task automatic sync_flags();
    bus.buf_empty    = (fifo_q.size() == 0);
    bus.fifo_counter = (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    sync_flags();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Observe at the falling edge, then update the FIFO model just after the rising edge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    cyc++;
    rd = bus.rd_enb;
    if (rd) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (rd && bus.buf_empty) empty_viol++;
    if (rd && !enable) en_viol++;
    if (burst_done) begin
      n_bd++;
      bd_rd = n_rd;
    end
    if (bus.m_valid && first_val < 0) first_val = cyc;
    if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stable_viol++;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    if (bus.m_valid && bus.m_ready) begin
      n_del++;
      got.push_back(bus.m_data);
      got_cyc.push_back(cyc);
      if (exp_q.size() == 0) order_err++;
      else if (exp_q.pop_front() !== bus.m_data) order_err++;
    end
    if (n_rd - n_del > max_out) max_out = n_rd - n_del;
    @(posedge clk);
    #1;
    if (rd) begin
      if (fifo_q.size() == 0) empty_viol++;
      else begin
        bus.data_out = fifo_q.pop_front();
        exp_q.push_back(bus.data_out);
      end
      sync_flags();
    end
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; n_rd = 0; n_del = 0; n_bd = 0; bd_rd = 0;
    empty_viol = 0; en_viol = 0; stable_viol = 0; order_err = 0; max_out = 0;
    first_rd = -1; first_val = -1; prev_stall = 1'b0; prev_data = '0;
    rst = 1'b1; enable = 1'b0; burst_mode = 1'b0; flush = 1'b0;
    bus.m_ready = 1'b0; bus.data_out = '0;
    sync_flags();
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_rd_enb", 32'(bus.rd_enb), 0);
    chk("rst_burst_done", 32'(burst_done), 0);

    // Continuous streaming of 0x11..0x15
    for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
    got.delete(); got_cyc.delete();
    bus.m_ready = 1'b1; enable = 1'b1;
    repeat (10) tick();
    chk("cont_count", 32'(got.size()), 5);
    for (int i = 0; i < 5; i++)
      chk("cont_data", 32'((got.size() > i) ? got[i] : 8'hxx), 32'(8'h11 + 8'(i)));
    chk("cont_consecutive", (got_cyc.size() == 5) ? 32'(got_cyc[4] - got_cyc[0]) : 32'hffff, 4);
    chk("cont_latency", 32'(first_val - first_rd), 2);
    chk("cont_rd_count", 32'(rd_count), 5);

    // Backpressure mid-stream
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    repeat (2) tick();
    bus.m_ready = 1'b0;
    repeat (6) tick();
    chk("bp_outstanding", 32'(n_rd - n_del), 2);
    chk("bp_stall_data", 32'(bus.m_data), 32'h20);
    bus.m_ready = 1'b1;
    repeat (12) tick();
    chk("bp_count", 32'(got.size()), 8);
    chk("bp_last", (got.size() == 8) ? 32'(got[7]) : 32'hffff, 32'h27);
    chk("bp_stable", 32'(stable_viol), 0);
    chk("bp_rd_count", 32'(rd_count), 13);

    // Enable falls after two reads
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    repeat (2) tick();
    enable = 1'b0;
    repeat (5) tick();
    chk("en_no_reads", 32'(en_viol), 0);
    chk("en_left_in_fifo", 32'(fifo_q.size()), 2);
    chk("en_drained", 32'(n_rd - n_del), 0);
    chk("en_rd_count", 32'(rd_count), 15);
    fifo_q.delete(); sync_flags();

    // Burst gated by threshold
    burst_mode = 1'b1; enable = 1'b1;
    base = n_rd; bd_base = n_bd;
    for (int i = 0; i < 3; i++) begin
      push(8'h40 + 8'(i));
      repeat (3) tick();
    end
    chk("burst_wait", 32'(n_rd - base), 0);
    push(8'h43);
    repeat (8) tick();
    chk("burst_reads", 32'(n_rd - base), 4);
    chk("burst_done_cnt", 32'(n_bd - bd_base), 1);
    chk("burst_done_on_4th", 32'(bd_rd - base), 4);
    chk("burst_rd_count", 32'(rd_count), 19);
    push(8'h50); push(8'h51);
    repeat (4) tick();
    chk("burst_back_to_fill", 32'(n_rd - base), 4);

    // Flush two words below threshold
    flush = 1'b1;
    repeat (6) tick();
    flush = 1'b0;
    chk("flush_reads", 32'(n_rd - base), 6);
    chk("flush_no_done", 32'(n_bd - bd_base), 1);
    chk("flush_rd_count", 32'(rd_count), 21);
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    repeat (4) tick();
    chk("flush_back_to_fill", 32'(n_rd - base), 6);
    push(8'h63);
    repeat (8) tick();
    chk("burst2_reads", 32'(n_rd - base), 10);
    chk("burst2_done_on_4th", 32'(bd_rd - base), 10);
    chk("burst2_done_cnt", 32'(n_bd - bd_base), 2);
    chk("order", 32'(order_err), 0);

    // Reset the cycle after a read issues
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    base = n_rd;
    for (int k = 0; k < 10 && n_rd == base; k++) tick();
    chk("rst_read_seen", 32'(n_rd - base), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; enable = 1'b0;
    exp_q.delete(); fifo_q.delete(); sync_flags();
    n_rd = n_del; dl = n_del;
    chk("rst_mid_m_valid", 32'(bus.m_valid), 0);
    chk("rst_mid_rd_count", 32'(rd_count), 0);
    repeat (4) tick();
    chk("rst_mid_no_xfer", 32'(n_del - dl), 0);
    chk("rst_mid_m_valid2", 32'(bus.m_valid), 0);

    // rd_count wrap
    burst_mode = 1'b0; enable = 1'b1;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 65534; i++) fifo_q.push_back(8'(i));
    sync_flags();
    for (int k = 0; k < 70000 && n_del - dl < 65534; k++) tick();
    repeat (3) tick();
    chk("wrap_delivered", 32'(n_del - dl), 65534);
    chk("wrap_fffe", 32'(rd_count), 32'hfffe);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 3; i++) push(8'ha0 + 8'(i));
    repeat (8) tick();
    chk("wrap_0001", 32'(rd_count), 1);
    chk("final_order", 32'(order_err), 0);
    chk("final_empty_reads", 32'(empty_viol), 0);
    chk("final_max_ahead", 32'(max_out <= 2), 1);
    chk("final_stable", 32'(stable_viol), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
